// File: rtl/sr_pulse_driver.sv
// sr_pulse_driver: debounced set/clear switches driving timed, non-overlapping S/R pulses into a NOR latch.
// Optional Q-feedback check: define SR_PULSE_DRIVER_CHECK_EN to enable err; otherwise err is tied low.

module sr_pulse_driver_deb #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic rise
);

  localparam logic [7:0] DEB_LD  = 8'(DEB_CYCLES - 1);
  localparam bit         DEB_ONE = (DEB_CYCLES == 1);

  logic       sync1;
  logic       sync2;
  logic       level;
  logic [7:0] cnt;

  // cnt holds the mismatch cycles still required; zero means no disagreement in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == 8'd1 || (cnt == 8'd0 && DEB_ONE)) begin
        level <= sync2;
        cnt   <= '0;
        rise  <= sync2;
      end else if (cnt == 8'd0) begin
        cnt <= DEB_LD;
      end else begin
        cnt <= cnt - 8'd1;
      end
    end
  end

endmodule

// state   | meaning
// IDLE    | outputs low, waiting for a pending or new command
// PULSE_S | s_out high for PULSE_CYCLES cycles
// PULSE_R | r_out high for PULSE_CYCLES cycles
// GAP     | both outputs low for GAP_CYCLES cycles
module sr_pulse_driver #(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned PULSE_CYCLES = 3,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic set_sw,
  input  logic clr_sw,
  input  logic q_fb,
  output logic s_out,
  output logic r_out,
  output logic busy,
  output logic conflict,
  output logic err
);

  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic       cmd_set;
  logic       cmd_clr;
  logic       pend_set;
  logic       pend_clr;
  logic       want_set;
  logic       want_clr;
  logic       start_s;
  logic       start_r;

  sr_pulse_driver_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .clk   (clk),
    .reset (reset),
    .sw    (set_sw),
    .rise  (cmd_set)
  );

  sr_pulse_driver_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk   (clk),
    .reset (reset),
    .sw    (clr_sw),
    .rise  (cmd_clr)
  );

  // a set arriving together with a clear is dropped; clear always wins
  assign want_clr = pend_clr | cmd_clr;
  assign want_set = pend_set | (cmd_set & ~cmd_clr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      pend_set <= 1'b0;
      pend_clr <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pend_clr <= start_r ? 1'b0 : want_clr;
      pend_set <= start_s ? 1'b0 : want_set;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start_s   = 1'b0;
    start_r   = 1'b0;
    case (state)
      IDLE: begin
        if (want_clr) begin
          state_nxt = PULSE_R;
          cnt_nxt   = PULSE_LD;
          start_r   = 1'b1;
        end else if (want_set) begin
          state_nxt = PULSE_S;
          cnt_nxt   = PULSE_LD;
          start_s   = 1'b1;
        end
      end
      PULSE_S, PULSE_R: begin
        if (cnt == 8'd0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LD;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      GAP: begin
        if (cnt == 8'd0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    s_out    = 1'b0;
    r_out    = 1'b0;
    busy     = 1'b0;
    conflict = 1'b0;
    s_out    = (state == PULSE_S);
    r_out    = (state == PULSE_R);
    busy     = (state != IDLE);
    conflict = cmd_set & cmd_clr;
  end

`ifdef SR_PULSE_DRIVER_CHECK_EN
  logic last_set;

  // latch Q must match the last serviced command by the final gap cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      last_set <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (start_s) begin
        last_set <= 1'b1;
      end else if (start_r) begin
        last_set <= 1'b0;
      end
      if (state == GAP && cnt == 8'd0 && q_fb != last_set) begin
        err <= 1'b1;
      end
    end
  end
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign err         = 1'b0;
`endif

endmodule
